// File: rtl/sram_pkg.sv
// Shared types and helpers for the SPI pixel path into the SRAM wrapper.
// Entry layout, resolution defaults and the wrapper's SPI commit condition.
package sram_pkg;

  localparam int X_RES_DEF = 800;
  localparam int Y_RES_DEF = 600;
  localparam int COORD_W   = 12;
  localparam int PIX_W     = 16;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic [PIX_W-1:0]   pixel;
  } q_entry_t;

  localparam int ENTRY_W = $bits(q_entry_t);

  // The wrapper commits an SPI write exactly when nothing else is
  // competing for the port; mirror that so pops track real writes.
  function automatic logic spi_pop(
    input logic active,
    input logic req,
    input logic adc
  );
    return active & ~req & ~adc;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Generic show-ahead FIFO with registered head, level, full and empty.
// The head register holds its last value while the FIFO is empty.
module sync_fifo #(
  parameter int W     = 40,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [W-1:0]             din,
  input  logic                     pop,
  output logic [W-1:0]             dout,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   lvl_nx;
  logic          do_push;
  logic          do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Next occupancy from the accepted push/pop pair.
  always_comb begin
    lvl_nx = level;
    if (do_push && !do_pop)
      lvl_nx = level + 1'b1;
    else if (!do_push && do_pop)
      lvl_nx = level - 1'b1;
  end

  // Storage array, written only at the tail; no reset needed.
  always_ff @(posedge clk) begin
    if (do_push)
      mem[wr_ptr] <= din;
  end

  // Pointers, status flags and the show-ahead head register.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
      dout   <= '0;
    end else begin
      if (do_push)
        wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)
        rd_ptr <= rd_ptr + 1'b1;
      level <= lvl_nx;
      full  <= (lvl_nx == (AW+1)'(DEPTH));
      empty <= (lvl_nx == '0);
      if (do_push && (do_pop ? (level == 1) : empty))
        dout <= din;
      else if (do_pop && level > 1)
        dout <= mem[rd_ptr + 1'b1];
    end
  end

endmodule

// File: rtl/spi_pixel_queue.sv
// Queues SPI pixels with raster x/y for the SRAM wrapper's SPI port.
// Optional drop counter: define SPI_QUEUE_DROP_COUNT_EN.
module spi_pixel_queue
  import sram_pkg::*;
#(
  parameter int X_RES = X_RES_DEF,
  parameter int Y_RES = Y_RES_DEF,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     origin_load,
  input  logic [COORD_W-1:0]       origin_x,
  input  logic [COORD_W-1:0]       origin_y,
  input  logic                     pixel_valid,
  input  logic [PIX_W-1:0]         pixel_data,
  output logic                     pixel_ready,
  input  logic                     request_active,
  input  logic                     adc_pixel_ready,
  output logic                     spi_active,
  output logic [PIX_W-1:0]         spi_pixel_in,
  output logic [COORD_W-1:0]       spi_pixel_x,
  output logic [COORD_W-1:0]       spi_pixel_y,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic                     origin_err,
`ifdef SPI_QUEUE_DROP_COUNT_EN
  output logic [15:0]              drop_count,
`endif
  output logic                     frame_done
);

  logic [COORD_W-1:0] cur_x, cur_y;
  logic [COORD_W-1:0] base_x, base_y;
  logic [COORD_W-1:0] nx_x, nx_y;
  logic               org_bad;
  logic               last_x, last_y;
  logic               push, full, empty, pop;
  q_entry_t           wr_ent, hd_ent;

  assign pixel_ready = ~full & ~rst;
  assign push        = pixel_valid & pixel_ready;
  assign spi_active  = ~empty;
  assign pop = spi_pop(spi_active, request_active, adc_pixel_ready);

  // Origin clamp, write coordinate selection and raster advance.
  always_comb begin
    org_bad = origin_x[COORD_W-1] | (origin_x >= COORD_W'(X_RES))
            | origin_y[COORD_W-1] | (origin_y >= COORD_W'(Y_RES));
    base_x = cur_x;
    base_y = cur_y;
    if (origin_load) begin
      base_x = org_bad ? '0 : origin_x;
      base_y = org_bad ? '0 : origin_y;
    end
    last_x = (base_x == COORD_W'(X_RES - 1));
    last_y = (base_y == COORD_W'(Y_RES - 1));
    nx_x = last_x ? '0 : base_x + 1'b1;
    nx_y = base_y;
    if (last_x)
      nx_y = last_y ? '0 : base_y + 1'b1;
    wr_ent = '{x: base_x, y: base_y, pixel: pixel_data};
  end

  sync_fifo #(
    .W     (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (wr_ent),
    .pop   (pop),
    .dout  (hd_ent),
    .level (level),
    .full  (full),
    .empty (empty)
  );

  assign spi_pixel_in = hd_ent.pixel;
  assign spi_pixel_x  = hd_ent.x;
  assign spi_pixel_y  = hd_ent.y;

  // Cursor state, sticky error flags and end-of-frame pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_x      <= '0;
      cur_y      <= '0;
      overflow   <= 1'b0;
      origin_err <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      if (push) begin
        cur_x <= nx_x;
        cur_y <= nx_y;
      end else if (origin_load) begin
        cur_x <= base_x;
        cur_y <= base_y;
      end
      if (pixel_valid && full)
        overflow <= 1'b1;
      if (origin_load && org_bad)
        origin_err <= 1'b1;
      frame_done <= push & last_x & last_y;
    end
  end

`ifdef SPI_QUEUE_DROP_COUNT_EN
  // Saturating count of pixels dropped against a full queue.
  always_ff @(posedge clk) begin
    if (rst)
      drop_count <= '0;
    else if (pixel_valid && full && drop_count != 16'hFFFF)
      drop_count <= drop_count + 1'b1;
  end
`endif

endmodule

// File: tb/tb_spi_pixel_queue.sv
// Directed plus random bench for spi_pixel_queue.
// Reference model works on linear raster indices and a queue of entries.
module tb_spi_pixel_queue;

  localparam int XR = 800;
  localparam int YR = 600;
  localparam int DP = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        origin_load = 1'b0;
  logic [11:0] origin_x = '0;
  logic [11:0] origin_y = '0;
  logic        pixel_valid = 1'b0;
  logic [15:0] pixel_data = '0;
  logic        pixel_ready;
  logic        request_active = 1'b0;
  logic        adc_pixel_ready = 1'b0;
  logic        spi_active;
  logic [15:0] spi_pixel_in;
  logic [11:0] spi_pixel_x;
  logic [11:0] spi_pixel_y;
  logic [4:0]  level;
  logic        overflow;
  logic        origin_err;
  logic        frame_done;
`ifdef SPI_QUEUE_DROP_COUNT_EN
  logic [15:0] drop_count;
`endif

  spi_pixel_queue #(
    .X_RES (XR),
    .Y_RES (YR),
    .DEPTH (DP)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .origin_load     (origin_load),
    .origin_x        (origin_x),
    .origin_y        (origin_y),
    .pixel_valid     (pixel_valid),
    .pixel_data      (pixel_data),
    .pixel_ready     (pixel_ready),
    .request_active  (request_active),
    .adc_pixel_ready (adc_pixel_ready),
    .spi_active      (spi_active),
    .spi_pixel_in    (spi_pixel_in),
    .spi_pixel_x     (spi_pixel_x),
    .spi_pixel_y     (spi_pixel_y),
    .level           (level),
    .overflow        (overflow),
    .origin_err      (origin_err),
`ifdef SPI_QUEUE_DROP_COUNT_EN
    .drop_count      (drop_count),
`endif
    .frame_done      (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          x;
    int          y;
    logic [15:0] p;
  } ent_t;

  ent_t mq[$];
  ent_t last;
  int   cur;
  bit   m_ovf, m_err, m_fd;
  int   m_drop;
  int   n_chk = 0;
  int   n_fail = 0;
  int   n_writes = 0;

  task automatic chk(input string tag, input logic [39:0] obs,
                     input logic [39:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    last   = '{0, 0, 16'h0};
    cur    = 0;
    m_ovf  = 0;
    m_err  = 0;
    m_fd   = 0;
    m_drop = 0;
  endtask

  // One clock: check at negedge, then advance the model on posedge.
  task automatic cyc();
    int  sz;
    bit  do_pop, do_push, do_drop;
    int  ox, oy;
    ent_t e;
    @(negedge clk);
    sz = mq.size();
    chk("pixel_ready", 40'(pixel_ready), 40'(!rst && sz < DP));
    chk("spi_active", 40'(spi_active), 40'(sz > 0));
    chk("level", 40'(level), 40'(sz));
    chk("overflow", 40'(overflow), 40'(m_ovf));
    chk("origin_err", 40'(origin_err), 40'(m_err));
    chk("frame_done", 40'(frame_done), 40'(m_fd));
    chk("head_pix", 40'(spi_pixel_in), 40'(last.p));
    chk("head_x", 40'(spi_pixel_x), 40'(12'(last.x)));
    chk("head_y", 40'(spi_pixel_y), 40'(12'(last.y)));
`ifdef SPI_QUEUE_DROP_COUNT_EN
    chk("drop_count", 40'(drop_count), 40'(m_drop));
`endif
    do_pop  = sz > 0 && !request_active && !adc_pixel_ready;
    do_push = pixel_valid && sz < DP;
    do_drop = pixel_valid && sz >= DP;
    ox = int'($signed(origin_x));
    oy = int'($signed(origin_y));
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      m_fd = 0;
      if (origin_load) begin
        if (ox < 0 || ox >= XR || oy < 0 || oy >= YR) begin
          cur   = 0;
          m_err = 1;
        end else begin
          cur = oy * XR + ox;
        end
      end
      if (do_pop) begin
        void'(mq.pop_front());
        n_writes++;
      end
      if (do_push) begin
        e = '{cur % XR, cur / XR, pixel_data};
        mq.push_back(e);
        m_fd = (cur == XR * YR - 1);
        cur  = (cur + 1) % (XR * YR);
      end
      if (do_drop) begin
        m_ovf = 1;
        if (m_drop < 16'hFFFF)
          m_drop++;
      end
      if (mq.size() > 0)
        last = mq[0];
    end
    #1;
  endtask

  task automatic idle(input int n);
    pixel_valid = 0;
    origin_load = 0;
    for (int i = 0; i < n; i++)
      cyc();
  endtask

  task automatic push_px(input int n);
    for (int i = 0; i < n; i++) begin
      pixel_valid = 1;
      pixel_data  = 16'($urandom);
      cyc();
      origin_load = 0;
    end
    pixel_valid = 0;
  endtask

  task automatic load_org(input int x, input int y);
    origin_load = 1;
    origin_x    = 12'(x);
    origin_y    = 12'(y);
  endtask

  initial begin
    model_reset();
    rst = 1;
    @(posedge clk);
    #1;
    cyc();
    cyc();
    rst = 0;
    idle(2);

    load_org(10, 5);
    idle(1);
    push_px(3);
    idle(4);

    load_org(798, 0);
    push_px(3);
    idle(4);

    load_org(799, 599);
    push_px(1);
    push_px(1);
    idle(4);

    request_active = 1;
    push_px(17);
    idle(1);
    request_active = 0;
    idle(18);

    load_org(-1, 700);
    idle(1);
    push_px(1);
    idle(3);

    adc_pixel_ready = 1;
    push_px(4);
    for (int i = 0; i < 4; i++) begin
      adc_pixel_ready = i[0];
      cyc();
    end
    rst = 1;
    cyc();
    rst = 0;
    adc_pixel_ready = 0;
    idle(2);

    for (int i = 0; i < 400; i++) begin
      pixel_valid     = ($urandom_range(0, 3) != 0);
      pixel_data      = 16'($urandom);
      request_active  = ($urandom_range(0, 3) == 0);
      adc_pixel_ready = ($urandom_range(0, 4) == 0);
      origin_load     = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 1) == 1) begin
        origin_x = 12'(int'($urandom_range(0, 900)) - 50);
        origin_y = 12'(int'($urandom_range(0, 700)) - 50);
      end else begin
        origin_x = 12'($urandom_range(796, 799));
        origin_y = 12'($urandom_range(598, 599));
      end
      if (i > 150 && i < 200)
        request_active = 1;
      if (i == 300)
        rst = 1;
      cyc();
      rst = 0;
    end
    request_active  = 0;
    adc_pixel_ready = 0;
    idle(DP + 2);

    chk("writes_seen", 40'(n_writes > 30), 40'(1));
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_pixel_queue.md
# spi_pixel_queue

Buffers image pixels arriving from the SPI receiver and presents them to the SRAM wrapper's SPI write port, so pixels are never lost while the wrapper is busy. It sits directly upstream of the SRAM wrapper and downstream of the SPI byte/command decoder. It generates x/y write coordinates from a loadable origin with raster auto-advance. It infers acceptance by snooping the wrapper's arbitration inputs, because the wrapper provides no acknowledge.

## Interface
- X_RES, 800, active pixels per line; cursor wraps at X_RES-1
- Y_RES, 600, active lines; cursor wraps at Y_RES-1
- DEPTH, 16, queue entries (power of two, ≥2)
- clk  in  1  system clock, all logic on posedge
- rst  in  1  synchronous, active-high reset
- origin_load  in  1  load write cursor from origin_x/origin_y
- origin_x  in  12  signed start column
- origin_y  in  12  signed start row
- pixel_valid  in  1  pixel_data valid this cycle
- pixel_data  in  16  RGB565 pixel
- pixel_ready  out  1  queue can accept (not full)
- request_active  in  1  snooped; same net as the wrapper's request_active
- adc_pixel_ready  in  1  snooped; same net as the wrapper's adc_pixel_ready
- spi_active  out  1  head entry valid; to wrapper
- spi_pixel_in  out  16  head pixel
- spi_pixel_x  out  12  signed head column
- spi_pixel_y  out  12  signed head row
- level  out  $clog2(DEPTH)+1  current occupancy
- overflow  out  1  sticky: pixel_valid seen while full
- origin_err  out  1  sticky: out-of-range origin loaded
- frame_done  out  1  one-cycle pulse when the pixel at (X_RES-1, Y_RES-1) is accepted

## Operation
- Push occurs when pixel_valid && pixel_ready. The entry {cursor_x, cursor_y, pixel_data} is written at the tail.
- Cursor advance after each push:
  - x+1.
  - At x==X_RES-1: x=0, y+1.
  - At (X_RES-1, Y_RES-1): wraps to (0,0) and pulses frame_done.
- origin_load:
  - Cursor is set to origin_x/origin_y.
  - If origin_x<0, origin_x≥X_RES, origin_y<0 or origin_y≥Y_RES, the cursor is set to (0,0) instead and origin_err is set.
  - Same-cycle origin_load and push: the pixel is written at the loaded (or clamped) origin, and the cursor becomes origin+1 (with wrap).
  - Entries already queued keep their original coordinates.
- Pop occurs when spi_active && !request_active && !adc_pixel_ready. This is exactly the condition under which the wrapper commits the SPI write on the same edge.
- Show-ahead queue: the spi_* outputs always reflect the head entry and hold stable until the pop edge.
- Full: pixel_ready=0. A push attempt sets overflow; the pixel is dropped and the cursor does not advance. There is no same-cycle pop-then-push bypass when full.
- Empty: spi_active=0; the spi_* data outputs hold their last values.
- Simultaneous push and pop with 0<level<DEPTH: level unchanged, both take effect.
- Sticky flags clear only on rst.

## Timing
- Reset values:
  - Outputs: pixel_ready=0 while rst is high, then 1 on the first cycle after; spi_active=0; spi_pixel_in/x/y=0; level=0; overflow=0; origin_err=0; frame_done=0.
  - Internal: cursor=(0,0).
- rst mid-operation flushes all entries; no write reaches the wrapper after the reset edge.
- Push-to-spi_active latency is 1 cycle: a pixel pushed at edge N is visible at the head after edge N.
- Pop: the head advances on the same edge the wrapper samples the entry. The next entry is visible the following cycle, giving 1 write/cycle sustained throughput when there is no contention.
- level and pixel_ready are registered and updated on the push/pop edge.
- frame_done asserts in the cycle after the final-pixel push edge.

## Configuration
- SPI_QUEUE_DROP_COUNT_EN defined: adds output drop_count (16 bits, reset 0). It increments on every dropped push and saturates at 16'hFFFF.
- Undefined: the drop_count port and counter are absent; only the sticky overflow flag reports drops.

## Structure
- Shared package sram_pkg holds:
  - X_RES/Y_RES defaults
  - Coordinate width (12)
  - Pixel width (16)
  - Queue entry type {x, y, pixel} (40 bits)
  - The pop-condition helper
- One sub-module: sync_fifo (generic show-ahead, registered level/full/empty), instantiated with entry width 40 and DEPTH.
- Cursor, origin clamp, flags and the optional counter live in the top module.

## Test plan
- Reset, origin (10,5), 3 pushes, request_active=0, adc_pixel_ready=0 -> wrapper sees (10,5),(11,5),(12,5) on 3 consecutive edges; level returns to 0.
- Origin (798,0), 3 pushes -> coordinates (798,0),(799,0),(0,1).
- Origin (799,599), 1 push -> frame_done pulses once; the next push lands at (0,0).
- request_active=1 held, 17 pushes with DEPTH=16 -> level=16, pixel_ready=0, overflow=1, drop_count=1 (with macro). Release request_active -> 16 pops in order, no gaps.
- Origin (-1,700) -> origin_err=1; the next pixel is queued at (0,0).
- adc_pixel_ready pulses on alternate cycles with 4 queued entries -> pops only on cycles with adc_pixel_ready=0; assert rst mid-drain -> spi_active=0 and level=0 the next cycle.
